// File: rtl/uop_issue_sched.sv
// Round-robin issue scheduler sharing one fixed-latency, non-stallable datapath
// between N_REQ requesters; results return in issue order through a credit-guarded FIFO.
module uop_issue_sched #(
    parameter int N_REQ      = 4,
    parameter int W          = 32,
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int SHW        = $clog2(W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_src,
    input  logic [N_REQ*SHW-1:0] req_shamt,
    output logic [W-1:0]         dp_src,
    output logic [SHW-1:0]       dp_shamt,
    input  logic [W-1:0]         dp_dst,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [IDW-1:0] rrPtr_q, rrPtr_d;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] hiIdx, loIdx;
    logic           hiFound;
    logic           issue;
    logic           pop;
    logic [CW-1:0]  outstanding_q, outstanding_d;
    logic           pushValid;
    logic [IDW-1:0] pushId;

    logic [W-1:0]   fifoData_q [FIFO_DEPTH];
    logic [IDW-1:0] fifoId_q   [FIFO_DEPTH];
    logic [PW-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0]  count_q, count_d;

    // Descending scan leaves the lowest valid index at or above the pointer in
    // hiIdx and the lowest valid index below it in loIdx; hi wins when present.
    always_comb begin
        hiFound = 1'b0;
        hiIdx   = '0;
        loIdx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i >= int'(rrPtr_q)) begin
                    hiFound = 1'b1;
                    hiIdx   = IDW'(i);
                end else begin
                    loIdx   = IDW'(i);
                end
            end
        end
        grant = hiFound ? hiIdx : loIdx;
    end

    assign issue = rst_n && (|req_valid) && (outstanding_q < CW'(FIFO_DEPTH));
    assign pop   = rsp_valid && rsp_ready;
    assign busy  = (outstanding_q != '0);

    always_comb begin
        req_ready = '0;
        dp_src    = '0;
        dp_shamt  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (issue && (grant == IDW'(i))) begin
                req_ready[i] = 1'b1;
                dp_src       = req_src[i*W +: W];
                dp_shamt     = req_shamt[i*SHW +: SHW];
            end
        end
    end

    always_comb begin
        rrPtr_d       = rrPtr_q;
        outstanding_d = outstanding_q;
        if (issue) begin
            rrPtr_d = (grant == IDW'(N_REQ - 1)) ? '0 : grant + IDW'(1);
        end
        if (issue && !pop) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!issue && pop) begin
            outstanding_d = outstanding_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr_q       <= '0;
            outstanding_q <= '0;
        end else begin
            rrPtr_q       <= rrPtr_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Valid/id travel beside the datapath; clearing them on reset drops in-flight results.
    generate
        if (LAT == 0) begin : g_noPipe
            assign pushValid = issue;
            assign pushId    = grant;
        end else begin : g_pipe
            logic [LAT-1:0] trkVld_q;
            logic [IDW-1:0] trkId_q [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    trkVld_q <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        trkId_q[i] <= '0;
                    end
                end else begin
                    trkVld_q[0] <= issue;
                    trkId_q[0]  <= grant;
                    for (int i = 1; i < LAT; i++) begin
                        trkVld_q[i] <= trkVld_q[i-1];
                        trkId_q[i]  <= trkId_q[i-1];
                    end
                end
            end

            assign pushValid = trkVld_q[LAT-1];
            assign pushId    = trkId_q[LAT-1];
        end
    endgenerate

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushValid) begin
            wrPtr_d = (wrPtr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rdPtr_q + PW'(1);
        end
        if (pushValid && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!pushValid && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Credits bound occupancy, so a push never finds the FIFO full without a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoData_q[i] <= '0;
                fifoId_q[i]   <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (pushValid) begin
                fifoData_q[wrPtr_q] <= dp_dst;
                fifoId_q[wrPtr_q]   <= pushId;
            end
        end
    end

    assign rsp_valid = (count_q != '0);
    assign rsp_data  = fifoData_q[rdPtr_q];
    assign rsp_id    = fifoId_q[rdPtr_q];

endmodule

// File: tb/tb_uop_issue_sched.sv
// Directed bench for uop_issue_sched: four instances (LAT 2, 1, 3, 0) with
// small behavioural datapaths, expected values computed by hand.
module tb_uop_issue_sched;

    logic         clk;
    logic         rst_n;
    logic         cRstN;
    logic [127:0] reqSrc;
    logic [19:0]  reqShamt;

    logic [3:0]  aValid, aReady, bValid, bReady, cValid, cReady, dValid, dReady;
    logic [31:0] aDpSrc, aDpDst, bDpSrc, bDpDst, cDpSrc, cDpDst, dDpSrc, dDpDst;
    logic [4:0]  aDpSh, bDpSh, cDpSh, dDpSh;
    logic        aRspValid, bRspValid, cRspValid, dRspValid;
    logic        aRspReady, bRspReady, cRspReady, dRspReady;
    logic [31:0] aRspData, bRspData, cRspData, dRspData;
    logic [1:0]  aRspId, bRspId, cRspId, dRspId;
    logic        aBusy, bBusy, cBusy, dBusy;

    logic [31:0] aS1, aS2, bS1, cS1, cS2, cS3;

    int errors = 0;
    int checks = 0;
    int bSeq;
    logic expReady;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural datapaths: identity pipes of depth 2/1/3 and a combinational +1.
    always @(posedge clk) begin
        aS1 <= aDpSrc;
        aS2 <= aS1;
        bS1 <= bDpSrc;
        cS1 <= cDpSrc;
        cS2 <= cS1;
        cS3 <= cS2;
    end
    assign aDpDst = aS2;
    assign bDpDst = bS1;
    assign cDpDst = cS3;
    assign dDpDst = dDpSrc + 32'd1;

    uop_issue_sched #(.N_REQ(4), .W(32), .LAT(2), .FIFO_DEPTH(4)) uA (
        .clk(clk), .rst_n(rst_n), .req_valid(aValid), .req_ready(aReady),
        .req_src(reqSrc), .req_shamt(reqShamt), .dp_src(aDpSrc), .dp_shamt(aDpSh),
        .dp_dst(aDpDst), .rsp_valid(aRspValid), .rsp_ready(aRspReady),
        .rsp_data(aRspData), .rsp_id(aRspId), .busy(aBusy));

    uop_issue_sched #(.N_REQ(4), .W(32), .LAT(1), .FIFO_DEPTH(4)) uB (
        .clk(clk), .rst_n(rst_n), .req_valid(bValid), .req_ready(bReady),
        .req_src(reqSrc), .req_shamt(reqShamt), .dp_src(bDpSrc), .dp_shamt(bDpSh),
        .dp_dst(bDpDst), .rsp_valid(bRspValid), .rsp_ready(bRspReady),
        .rsp_data(bRspData), .rsp_id(bRspId), .busy(bBusy));

    uop_issue_sched #(.N_REQ(4), .W(32), .LAT(3), .FIFO_DEPTH(4)) uC (
        .clk(clk), .rst_n(cRstN), .req_valid(cValid), .req_ready(cReady),
        .req_src(reqSrc), .req_shamt(reqShamt), .dp_src(cDpSrc), .dp_shamt(cDpSh),
        .dp_dst(cDpDst), .rsp_valid(cRspValid), .rsp_ready(cRspReady),
        .rsp_data(cRspData), .rsp_id(cRspId), .busy(cBusy));

    uop_issue_sched #(.N_REQ(4), .W(32), .LAT(0), .FIFO_DEPTH(4)) uD (
        .clk(clk), .rst_n(rst_n), .req_valid(dValid), .req_ready(dReady),
        .req_src(reqSrc), .req_shamt(reqShamt), .dp_src(dDpSrc), .dp_shamt(dDpSh),
        .dp_dst(dDpDst), .rsp_valid(dRspValid), .rsp_ready(dRspReady),
        .rsp_data(dRspData), .rsp_id(dRspId), .busy(dBusy));

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [31:0] value);
        reqSrc[idx*32 +: 32] = value;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n     = 1'b0;
        cRstN     = 1'b0;
        reqSrc    = '0;
        reqShamt  = '0;
        aValid    = 4'hF;
        bValid    = '0;
        cValid    = '0;
        dValid    = '0;
        aRspReady = 1'b0;
        bRspReady = 1'b0;
        cRspReady = 1'b0;
        dRspReady = 1'b0;

        #12;
        checkOutput("rstReadyA", aReady, 4'b0000);
        checkOutput("rstBusyA", aBusy, 0);
        checkOutput("rstRspValidA", aRspValid, 0);
        checkOutput("rstRspDataA", aRspData, 0);
        checkOutput("rstRspIdA", aRspId, 0);
        aValid = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cRstN = 1'b1;
        stepCycle();

        // Single request through the LAT=2 instance
        applyStimulus(1, 32'hDEAD_BEEF);
        aValid    = 4'b0010;
        aRspReady = 1'b1;
        #1;
        checkOutput("t1Ready", aReady, 4'b0010);
        checkOutput("t1DpSrc", aDpSrc, 32'hDEAD_BEEF);
        stepCycle();
        aValid = '0;
        #1;
        checkOutput("t1BusyC1", aBusy, 1);
        checkOutput("t1RspValidC1", aRspValid, 0);
        stepCycle();
        checkOutput("t1BusyC2", aBusy, 1);
        checkOutput("t1RspValidC2", aRspValid, 0);
        stepCycle();
        checkOutput("t1RspValidC3", aRspValid, 1);
        checkOutput("t1RspDataC3", aRspData, 32'hDEAD_BEEF);
        checkOutput("t1RspIdC3", aRspId, 1);
        checkOutput("t1BusyC3", aBusy, 1);
        stepCycle();
        checkOutput("t1BusyC4", aBusy, 0);
        checkOutput("t1RspValidC4", aRspValid, 0);

        // Round-robin with all requesters valid
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        for (int k = 0; k < 12; k++) begin
            aValid = (k < 8) ? 4'hF : 4'h0;
            for (int i = 0; i < 4; i++) applyStimulus(i, 32'hC0DE_0000 + i);
            #1;
            if (k < 8) checkOutput("t2Grant", aReady, 4'b0001 << (k % 4));
            checkOutput("t2RspValid", aRspValid, (k >= 3 && k < 11));
            if (k >= 3 && k < 11) begin
                checkOutput("t2RspId", aRspId, (k - 3) % 4);
                checkOutput("t2RspData", aRspData, 32'hC0DE_0000 + (k - 3) % 4);
            end
            stepCycle();
        end

        // Credit exhaustion, single-pop credit return, then sustained flow (LAT=1)
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        bSeq   = 0;
        bValid = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            bRspReady = (k == 6) || (k >= 8);
            applyStimulus(0, 32'h100 + bSeq);
            #1;
            expReady = (k < 4) || (k == 7) || (k >= 9);
            checkOutput("t3Ready", bReady, {3'b000, expReady});
            if (k == 5) begin
                checkOutput("t3HoldValid", bRspValid, 1);
                checkOutput("t3HoldData", bRspData, 32'h100);
                checkOutput("t3Busy", bBusy, 1);
            end
            if (k == 6) begin
                checkOutput("t3PopData", bRspData, 32'h100);
                checkOutput("t3PopId", bRspId, 0);
            end
            if (k >= 8) begin
                checkOutput("t4RspValid", bRspValid, 1);
                checkOutput("t4RspData", bRspData, 32'h101 + (k - 8));
                checkOutput("t4RspId", bRspId, 0);
            end
            if (expReady) bSeq++;
            stepCycle();
        end
        bValid    = '0;
        bRspReady = 1'b0;

        // Reset while three operations are in flight (LAT=3)
        cValid    = 4'b0111;
        cRspReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("t5Grant", cReady, 4'b0001 << k);
            stepCycle();
        end
        cValid = '0;
        #1;
        checkOutput("t5BusyBefore", cBusy, 1);
        cRstN = 1'b0;
        #1;
        checkOutput("t5BusyAtReset", cBusy, 0);
        checkOutput("t5RspValidAtReset", cRspValid, 0);
        stepCycle();
        cRstN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            stepCycle();
            checkOutput("t5RspValidAfter", cRspValid, 0);
            checkOutput("t5BusyAfter", cBusy, 0);
        end

        // Combinational datapath (LAT=0), y = src + 1
        applyStimulus(2, 32'h0000_0005);
        reqShamt[2*5 +: 5] = 5'd7;
        dValid    = 4'b0100;
        dRspReady = 1'b1;
        #1;
        checkOutput("t6Ready", dReady, 4'b0100);
        checkOutput("t6DpSrc", dDpSrc, 32'h0000_0005);
        checkOutput("t6DpShamt", dDpSh, 5'd7);
        stepCycle();
        dValid = '0;
        #1;
        checkOutput("t6RspValid", dRspValid, 1);
        checkOutput("t6RspData", dRspData, 32'h0000_0006);
        checkOutput("t6RspId", dRspId, 2);
        checkOutput("t6Busy", dBusy, 1);
        checkOutput("t6IdleDpSrc", dDpSrc, 0);
        stepCycle();
        checkOutput("t6RspValidAfter", dRspValid, 0);
        checkOutput("t6BusyAfter", dBusy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
